// File: rtl/imem_loader.sv
// Boot loader that unpacks a framed, XOR-checksummed byte stream into 32-bit
// big-endian instruction words and keeps the CPU held until the frame verifies.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 2**ADDR_W - BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_W  = 32'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [7:0]          chk_q, chk_d;
  logic [23:0]         word_buf_q, word_buf_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic        xfer;
  logic [15:0] hdr_count;

  assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign hdr_count  = {cnt_hi_q, byte_data};

  always_comb begin
    state_d      = state_q;
    cnt_hi_d     = cnt_hi_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    chk_d        = chk_q;
    word_buf_d   = word_buf_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          cnt_hi_d = byte_data;
          chk_d    = chk_q ^ byte_data;
          state_d  = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          chk_d        = chk_q ^ byte_data;
          words_left_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = S_CHECK;
          end else if ({16'd0, hdr_count} > MAX_W) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_d      = chk_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    word_buf_d[23:16] = byte_data;
            2'd1:    word_buf_d[15:8]  = byte_data;
            2'd2:    word_buf_d[7:0]   = byte_data;
            default: begin
              // Last lane goes straight to the write register, one cycle latency.
              mem_we_d     = 1'b1;
              mem_addr_d   = BASE_A + word_idx_q;
              mem_wdata_d  = {word_buf_q, byte_data};
              word_idx_d   = word_idx_q + ADDR_W'(1);
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (byte_data == chk_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HDR_HI;
      cnt_hi_q     <= 8'd0;
      words_left_q <= 16'd0;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= '0;
      chk_q        <= 8'd0;
      word_buf_q   <= 24'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_A;
      mem_wdata_q  <= 32'd0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      chk_q        <= chk_d;
      word_buf_q   <= word_buf_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus queues expected writes and a
// monitor pops them as mem_we pulses; frame status is checked after each CHK.
module tb_imem_loader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        sel2 = 1'b0;

  logic        bv1, rdy1, we1, hold1, done1, err1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic        bv2, rdy2, we2, hold2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic        rdy_mux;

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_q[$];
  logic [7:0] tx_q[$];

  assign bv1     = byte_valid && !sel2;
  assign bv2     = byte_valid && sel2;
  assign rdy_mux = sel2 ? rdy2 : rdy1;

  imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .byte_valid(bv1), .byte_data(byte_data),
    .byte_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  imem_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .byte_valid(bv2), .byte_data(byte_data),
    .byte_ready(rdy2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .cpu_hold(hold2), .done(done2), .error(err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr1, wdata1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {22'd0, addr1}, {22'd0, e.addr});
        check("write_data", wdata1, e.data);
      end
    end
    if (we2 === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut2_write: got addr %0h data %0h expected no write", addr2, wdata2);
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    logic rdy;
    bit   sent;
    repeat ($urandom_range(gap_max, 0)) @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    sent       = 1'b0;
    for (int i = 0; i < 20 && !sent; i++) begin
      rdy = rdy_mux;
      @(posedge clk);
      #1;
      if (rdy) sent = 1'b1;
    end
    byte_valid = 1'b0;
    if (!sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready=0 for 20 cycles expected ready=1 for byte %0h", b);
    end
  endtask

  task automatic send_frame(input int unsigned gap_max);
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), gap_max);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic good_frame(input int unsigned gap);
    do_reset();
    push_wr(10'd0, 32'h2008_0005);
    push_wr(10'd1, 32'h8C09_0004);
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAE};
    send_frame(gap);
    check("good_done", {31'd0, done1}, 1);
    check("good_hold", {31'd0, hold1}, 0);
    check("good_ready", {31'd0, rdy1}, 0);
    check("good_error", {31'd0, err1}, 0);
    wait_drain("good_drained");
  endtask

  task automatic reset_mid_frame(input int unsigned gap);
    do_reset();
    tx_q = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send_frame(gap);
    do_reset();
    push_wr(10'd0, 32'h1234_5678);
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_frame(gap);
    check("rst_done", {31'd0, done1}, 1);
    check("rst_hold", {31'd0, hold1}, 0);
    check("rst_error", {31'd0, err1}, 0);
    wait_drain("rst_drained");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_hold", {31'd0, hold1}, 1);
    check("reset_done", {31'd0, done1}, 0);
    check("reset_error", {31'd0, err1}, 0);
    check("reset_we", {31'd0, we1}, 0);
    check("reset_ready", {31'd0, rdy1}, 1);
    check("reset_addr", {22'd0, addr1}, 0);
    check("reset_wdata", wdata1, 0);

    good_frame(0);

    do_reset();
    push_wr(10'd0, 32'h2008_0005);
    push_wr(10'd1, 32'h8C09_0004);
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAF};
    send_frame(0);
    check("badchk_error", {31'd0, err1}, 1);
    check("badchk_done", {31'd0, done1}, 0);
    check("badchk_hold", {31'd0, hold1}, 1);
    check("badchk_ready", {31'd0, rdy1}, 0);
    wait_drain("badchk_drained");

    do_reset();
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("empty_done", {31'd0, done1}, 1);
    check("empty_hold", {31'd0, hold1}, 0);
    wait_drain("empty_drained");

    do_reset();
    tx_q = '{8'h00, 8'h00, 8'h01};
    send_frame(0);
    check("empty_bad_error", {31'd0, err1}, 1);
    check("empty_bad_done", {31'd0, done1}, 0);

    do_reset();
    sel2 = 1'b1;
    tx_q = '{8'h00, 8'h05};
    send_frame(0);
    check("oversize_error", {31'd0, err2}, 1);
    check("oversize_ready", {31'd0, rdy2}, 0);
    check("oversize_done", {31'd0, done2}, 0);
    check("oversize_hold", {31'd0, hold2}, 1);
    sel2 = 1'b0;

    reset_mid_frame(0);
    reset_mid_frame(3);
    good_frame(3);

    check("last_addr_held", {22'd0, addr1}, 32'd1);
    check("last_data_held", wdata1, 32'h8C09_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
